// File: rtl/alu_ctrl_sequencer.sv
// 4004-style instruction-cycle sequencer: fetches OPR/OPA from the nibble bus,
// decodes them into ALU selects and issues one-cycle write strobes in X2.
module alu_ctrl_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       halt,
  input  logic [3:0] bus_in,
  output logic [2:0] phase,
  output logic       sync,
  output logic [3:0] opr,
  output logic [3:0] opa,
  output logic [2:0] alu_op,
  output logic [2:0] alu_in0_sel,
  output logic [1:0] alu_in1_sel,
  output logic [1:0] alu_cin_sel,
  output logic [3:0] alu_data,
  output logic [3:0] reg_addr,
  output logic       acc_we,
  output logic       carry_we,
  output logic       reg_we,
  output logic       illegal
);

  localparam logic [2:0] ALU_OP_PASS  = 3'd0;
  localparam logic [2:0] ALU_OP_ADD   = 3'd1;
  localparam logic [2:0] ALU_OP_ROL   = 3'd2;
  localparam logic [2:0] ALU_OP_ROR   = 3'd3;
  localparam logic [2:0] ALU_OP_DEC_A = 3'd4;
  localparam logic [2:0] ALU_OP_LG2_1 = 3'd5;

  localparam logic [2:0] ALU_IN0_ACC     = 3'd0;
  localparam logic [2:0] ALU_IN0_ACC_INV = 3'd1;
  localparam logic [2:0] ALU_IN0_REG     = 3'd2;
  localparam logic [2:0] ALU_IN0_REG_INV = 3'd3;
  localparam logic [2:0] ALU_IN0_DATA    = 3'd4;

  localparam logic [1:0] ALU_IN1_ACC     = 2'd0;
  localparam logic [1:0] ALU_IN1_ONE     = 2'd1;
  localparam logic [1:0] ALU_IN1_ONE_INV = 2'd2;

  localparam logic [1:0] ALU_CIN_CARRY     = 2'd0;
  localparam logic [1:0] ALU_CIN_CARRY_INV = 2'd1;
  localparam logic [1:0] ALU_CIN_ZERO      = 2'd2;
  localparam logic [1:0] ALU_CIN_ONE       = 2'd3;

  typedef enum logic {StRun, StHalt} state_e;

  state_e     state_q;
  logic       pend_acc_q, pend_carry_q, pend_reg_q;
  logic [2:0] dec_op, dec_in0;
  logic [1:0] dec_in1, dec_cin;
  logic       dec_acc, dec_carry, dec_reg, dec_illegal;

  // Decodes the captured OPR with the OPA nibble arriving on the bus this cycle.
  always_comb begin
    dec_op      = ALU_OP_PASS;
    dec_in0     = ALU_IN0_ACC;
    dec_in1     = ALU_IN1_ACC;
    dec_cin     = ALU_CIN_CARRY;
    dec_acc     = 1'b0;
    dec_carry   = 1'b0;
    dec_reg     = 1'b0;
    dec_illegal = 1'b0;
    case (opr)
      4'h6: begin
        dec_op = ALU_OP_ADD; dec_in0 = ALU_IN0_REG; dec_in1 = ALU_IN1_ONE;
        dec_cin = ALU_CIN_ZERO; dec_reg = 1'b1;
      end
      4'h8: begin
        dec_op = ALU_OP_ADD; dec_in0 = ALU_IN0_REG; dec_acc = 1'b1; dec_carry = 1'b1;
      end
      4'h9: begin
        dec_op = ALU_OP_ADD; dec_in0 = ALU_IN0_REG_INV; dec_cin = ALU_CIN_CARRY_INV;
        dec_acc = 1'b1; dec_carry = 1'b1;
      end
      4'hA: begin dec_in0 = ALU_IN0_REG;  dec_acc = 1'b1; end
      4'hD: begin dec_in0 = ALU_IN0_DATA; dec_acc = 1'b1; end
      4'hF: begin
        dec_acc   = 1'b1;
        dec_carry = 1'b1;
        case (bus_in)
          4'h0: begin dec_in0 = ALU_IN0_DATA; dec_cin = ALU_CIN_ZERO; end
          4'h1: dec_cin = ALU_CIN_ZERO;
          4'h2: begin dec_op = ALU_OP_ADD; dec_in1 = ALU_IN1_ONE; dec_cin = ALU_CIN_ZERO; end
          4'h3: dec_cin = ALU_CIN_CARRY_INV;
          4'h4: begin dec_in0 = ALU_IN0_ACC_INV; dec_carry = 1'b0; end
          4'h5: dec_op = ALU_OP_ROL;
          4'h6: dec_op = ALU_OP_ROR;
          4'h8: begin dec_op = ALU_OP_ADD; dec_in1 = ALU_IN1_ONE_INV; dec_cin = ALU_CIN_ONE; end
          4'hA: dec_cin = ALU_CIN_ONE;
          4'hB: dec_op = ALU_OP_DEC_A;
          4'hC: begin dec_op = ALU_OP_LG2_1; dec_carry = 1'b0; end
          default: begin dec_acc = 1'b0; dec_carry = 1'b0; dec_illegal = 1'b1; end
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StRun;
      phase        <= 3'd0;
      sync         <= 1'b0;
      opr          <= 4'h0;
      opa          <= 4'h0;
      alu_op       <= ALU_OP_PASS;
      alu_in0_sel  <= ALU_IN0_ACC;
      alu_in1_sel  <= ALU_IN1_ACC;
      alu_cin_sel  <= ALU_CIN_CARRY;
      illegal      <= 1'b0;
      acc_we       <= 1'b0;
      carry_we     <= 1'b0;
      reg_we       <= 1'b0;
      pend_acc_q   <= 1'b0;
      pend_carry_q <= 1'b0;
      pend_reg_q   <= 1'b0;
    end else begin
      acc_we   <= 1'b0;
      carry_we <= 1'b0;
      reg_we   <= 1'b0;
      sync     <= 1'b0;
      unique case (state_q)
        StRun: begin
          phase <= phase + 3'd1;
          sync  <= (phase == 3'd6);
          if (phase == 3'd3) opr <= bus_in;
          // Selects and illegal become visible as X1 starts.
          if (phase == 3'd4) begin
            opa          <= bus_in;
            alu_op       <= dec_op;
            alu_in0_sel  <= dec_in0;
            alu_in1_sel  <= dec_in1;
            alu_cin_sel  <= dec_cin;
            illegal      <= dec_illegal;
            pend_acc_q   <= dec_acc;
            pend_carry_q <= dec_carry;
            pend_reg_q   <= dec_reg;
          end
          if (phase == 3'd5) begin
            acc_we   <= pend_acc_q;
            carry_we <= pend_carry_q;
            reg_we   <= pend_reg_q;
          end
          if (phase == 3'd7 && halt) state_q <= StHalt;
        end
        StHalt: begin
          phase <= 3'd0;
          if (!halt) state_q <= StRun;
        end
      endcase
    end
  end

  assign alu_data = opa;
  assign reg_addr = opa;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Bench for alu_ctrl_sequencer: directed scenarios plus random traffic, all
// outputs compared every cycle against an instruction-level reference model.
module tb_alu_ctrl_sequencer;

  localparam logic [2:0] OP_PASS = 3'd0, OP_ADD = 3'd1, OP_ROL = 3'd2, OP_ROR = 3'd3,
                         OP_DAA = 3'd4, OP_KBP = 3'd5;
  localparam logic [2:0] I0_ACC = 3'd0, I0_ACC_INV = 3'd1, I0_REG = 3'd2, I0_REG_INV = 3'd3,
                         I0_DATA = 3'd4;
  localparam logic [1:0] I1_ACC = 2'd0, I1_ONE = 2'd1, I1_ONE_INV = 2'd2;
  localparam logic [1:0] C_CARRY = 2'd0, C_CARRY_INV = 2'd1, C_ZERO = 2'd2, C_ONE = 2'd3;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] in0;
    logic [1:0] in1;
    logic [1:0] cin;
    logic       acc;
    logic       cy;
    logic       rg;
    logic       ill;
  } ctrl_t;

  logic       clock, reset, halt;
  logic [3:0] bus_in;
  logic [2:0] phase, alu_op, alu_in0_sel;
  logic       sync, acc_we, carry_we, reg_we, illegal;
  logic [3:0] opr, opa, alu_data, reg_addr;
  logic [1:0] alu_in1_sel, alu_cin_sel;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Reference model state
  int         m_phase;
  bit         m_halt;
  logic [3:0] m_opr, m_opa;
  ctrl_t      m_ctrl;

  alu_ctrl_sequencer dut (
    .clock(clock), .reset(reset), .halt(halt), .bus_in(bus_in),
    .phase(phase), .sync(sync), .opr(opr), .opa(opa),
    .alu_op(alu_op), .alu_in0_sel(alu_in0_sel), .alu_in1_sel(alu_in1_sel),
    .alu_cin_sel(alu_cin_sel), .alu_data(alu_data), .reg_addr(reg_addr),
    .acc_we(acc_we), .carry_we(carry_we), .reg_we(reg_we), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ctrl_t mk(input logic [2:0] op, input logic [2:0] in0, input logic [1:0] in1,
                               input logic [1:0] cin, input logic acc, input logic cy,
                               input logic rg);
    ctrl_t c;
    c.op = op; c.in0 = in0; c.in1 = in1; c.cin = cin;
    c.acc = acc; c.cy = cy; c.rg = rg; c.ill = 1'b0;
    return c;
  endfunction

  function automatic ctrl_t ref_decode(input logic [7:0] code);
    ctrl_t c;
    casez (code)
      8'h6?: c = mk(OP_ADD,  I0_REG,     I1_ONE,     C_ZERO,      0, 0, 1);
      8'h8?: c = mk(OP_ADD,  I0_REG,     I1_ACC,     C_CARRY,     1, 1, 0);
      8'h9?: c = mk(OP_ADD,  I0_REG_INV, I1_ACC,     C_CARRY_INV, 1, 1, 0);
      8'hA?: c = mk(OP_PASS, I0_REG,     I1_ACC,     C_CARRY,     1, 0, 0);
      8'hD?: c = mk(OP_PASS, I0_DATA,    I1_ACC,     C_CARRY,     1, 0, 0);
      8'hF0: c = mk(OP_PASS, I0_DATA,    I1_ACC,     C_ZERO,      1, 1, 0);
      8'hF1: c = mk(OP_PASS, I0_ACC,     I1_ACC,     C_ZERO,      1, 1, 0);
      8'hF2: c = mk(OP_ADD,  I0_ACC,     I1_ONE,     C_ZERO,      1, 1, 0);
      8'hF3: c = mk(OP_PASS, I0_ACC,     I1_ACC,     C_CARRY_INV, 1, 1, 0);
      8'hF4: c = mk(OP_PASS, I0_ACC_INV, I1_ACC,     C_CARRY,     1, 0, 0);
      8'hF5: c = mk(OP_ROL,  I0_ACC,     I1_ACC,     C_CARRY,     1, 1, 0);
      8'hF6: c = mk(OP_ROR,  I0_ACC,     I1_ACC,     C_CARRY,     1, 1, 0);
      8'hF8: c = mk(OP_ADD,  I0_ACC,     I1_ONE_INV, C_ONE,       1, 1, 0);
      8'hFA: c = mk(OP_PASS, I0_ACC,     I1_ACC,     C_ONE,       1, 1, 0);
      8'hFB: c = mk(OP_DAA,  I0_ACC,     I1_ACC,     C_CARRY,     1, 1, 0);
      8'hFC: c = mk(OP_KBP,  I0_ACC,     I1_ACC,     C_CARRY,     1, 0, 0);
      default: begin
        c = mk(OP_PASS, I0_ACC, I1_ACC, C_CARRY, 0, 0, 0);
        c.ill = 1'b1;
      end
    endcase
    return c;
  endfunction

  // Model: instruction-level view of the 8-phase cycle, advanced once per clock.
  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0; m_halt = 0; m_opr = 4'h0; m_opa = 4'h0;
      m_ctrl  = mk(OP_PASS, I0_ACC, I1_ACC, C_CARRY, 0, 0, 0);
    end else if (m_halt) begin
      if (!halt) m_halt = 0;
    end else begin
      if (m_phase == 3) m_opr = bus_in;
      if (m_phase == 4) begin
        m_opa  = bus_in;
        m_ctrl = ref_decode({m_opr, m_opa});
      end
      if (m_phase == 7 && halt) m_halt = 1;
      m_phase = (m_phase + 1) % 8;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      bit x2;
      x2 = !m_halt && m_phase == 6;
      check("phase", phase, m_phase);
      check("sync", sync, !m_halt && m_phase == 7);
      check("opr", opr, m_opr);
      check("opa", opa, m_opa);
      check("alu_data", alu_data, m_opa);
      check("reg_addr", reg_addr, m_opa);
      check("alu_op", alu_op, m_ctrl.op);
      check("alu_in0_sel", alu_in0_sel, m_ctrl.in0);
      check("alu_in1_sel", alu_in1_sel, m_ctrl.in1);
      check("alu_cin_sel", alu_cin_sel, m_ctrl.cin);
      check("illegal", illegal, m_ctrl.ill);
      check("acc_we", acc_we, x2 && m_ctrl.acc);
      check("carry_we", carry_we, x2 && m_ctrl.cy);
      check("reg_we", reg_we, x2 && m_ctrl.rg);
    end
  end

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(m_phase == p && !m_halt) && n < 64);
    if (!(m_phase == p && !m_halt)) begin
      total++; bad++;
      $display("FAIL wait_phase: got phase %0d want %0d within 64 clocks", m_phase, p);
    end
  endtask

  task automatic fetch(input logic [3:0] o_r, input logic [3:0] o_a);
    wait_phase(3); bus_in = o_r;
    wait_phase(4); bus_in = o_a;
    wait_phase(5); bus_in = 4'($urandom);
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; bus_in = 4'h0;
    repeat (2) @(negedge clock);
    chk_en = 1; reset = 1'b0;

    // Free run with opcode 0x00 (illegal)
    for (int i = 0; i < 16; i++) begin
      check("lit_seq_phase", phase, i % 8);
      check("lit_seq_sync", sync, (i % 8) == 7);
      if (i % 8 == 6) begin
        check("lit_seq_strobes", {acc_we, carry_we, reg_we}, 0);
        check("lit_seq_illegal", illegal, 1);
      end
      @(negedge clock);
    end

    // IAC
    fetch(4'hF, 4'h2);
    wait_phase(6);
    check("lit_iac_op", alu_op, 1);
    check("lit_iac_in1", alu_in1_sel, 1);
    check("lit_iac_cin", alu_cin_sel, 2);
    check("lit_iac_we", {acc_we, carry_we, reg_we}, 3'b110);
    check("lit_iac_illegal", illegal, 0);
    @(negedge clock);
    check("lit_iac_x3_we", {acc_we, carry_we, reg_we}, 0);

    // SUB R5, INC R3
    fetch(4'h9, 4'h5);
    wait_phase(6);
    check("lit_sub_addr", reg_addr, 5);
    check("lit_sub_data", alu_data, 5);
    check("lit_sub_in0", alu_in0_sel, 3);
    check("lit_sub_cin", alu_cin_sel, 1);
    check("lit_sub_we", {acc_we, carry_we, reg_we}, 3'b110);
    fetch(4'h6, 4'h3);
    wait_phase(6);
    check("lit_inc_we", {acc_we, carry_we, reg_we}, 3'b001);
    check("lit_inc_in1", alu_in1_sel, 1);

    // Illegal F7 then CLB
    fetch(4'hF, 4'h7);
    check("lit_ill_x1", illegal, 1);
    wait_phase(6);
    check("lit_ill_we", {acc_we, carry_we, reg_we}, 0);
    wait_phase(2);
    check("lit_ill_held", illegal, 1);
    fetch(4'hF, 4'h0);
    check("lit_clb_illegal", illegal, 0);
    wait_phase(6);
    check("lit_clb_in0", alu_in0_sel, 4);
    check("lit_clb_we", {acc_we, carry_we, reg_we}, 3'b110);

    // Halt outside X3 is ignored
    wait_phase(2); halt = 1'b1;
    wait_phase(5); halt = 1'b0;
    wait_phase(7);
    @(negedge clock);
    check("lit_nohalt_p0", phase, 0);
    @(negedge clock);
    check("lit_nohalt_p1", phase, 1);

    // Halt held across X3
    wait_phase(6); halt = 1'b1;
    wait_phase(7);
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      check("lit_halt_phase", phase, 0);
      check("lit_halt_sync", sync, 0);
      @(negedge clock);
    end
    halt = 1'b0;
    @(negedge clock);
    check("lit_resume_p0", phase, 0);
    @(negedge clock);
    check("lit_resume_p1", phase, 1);
    fetch(4'hF, 4'h2);
    wait_phase(6);
    check("lit_resume_we", {acc_we, carry_we}, 2'b11);

    // Reset during ADD's X2
    fetch(4'h8, 4'h3);
    wait_phase(6);
    check("lit_add_we", {acc_we, carry_we}, 2'b11);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("lit_rst_we", {acc_we, carry_we, reg_we}, 0);
    check("lit_rst_phase", phase, 0);
    check("lit_rst_opcode", {opr, opa}, 0);

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      reset  = ($urandom_range(0, 149) == 0);
      halt   = ($urandom_range(0, 5) == 0);
      bus_in = (m_phase == 3 && $urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
    end
    reset = 1'b0; halt = 1'b0;
    repeat (10) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
- Instruction-cycle sequencer and decoder that drives the ALU select/op inputs and the accumulator/carry/register write strobes.
- Runs the 8-phase 4004 instruction cycle: A1 A2 A3 M1 M2 X1 X2 X3.
- Captures the OPR/OPA opcode nibbles from the 4-bit bus in M1/M2 and decodes them during X1.
- Presents ALU controls plus single-cycle write enables in X2. The datapath commits the ALU result at the end of X2.

Parameters:
- none (select and op codes are the shared datapath constants ALU_OP_*, ALU_IN0_*, ALU_IN1_*, ALU_CIN_*).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- halt  in  1  request to park after the current instruction.
- bus_in  in  4  instruction nibble bus.
- phase  out  3  current phase, 0=A1 .. 7=X3.
- sync  out  1  high during X3 only.
- opr  out  4  captured upper opcode nibble.
- opa  out  4  captured lower opcode nibble.
- alu_op  out  3  ALU operation.
- alu_in0_sel  out  3  ALU operand-0 select.
- alu_in1_sel  out  2  ALU operand-1 select.
- alu_cin_sel  out  2  ALU carry-in select.
- alu_data  out  4  ALU data operand; always equals opa.
- reg_addr  out  4  index register address; always equals opa.
- acc_we  out  1  accumulator write strobe.
- carry_we  out  1  carry write strobe (takes result[4]).
- reg_we  out  1  index register write strobe.
- illegal  out  1  unsupported opcode flag.

Behaviour:
- All outputs are registered.
- Reset values: phase=0, sync=0, opr=0, opa=0, acc_we/carry_we/reg_we=0, illegal=0, alu_op=PASS, in0=ACC, in1=ACC, cin=CARRY.
- FSM states:
  - RUN: phase increments every clock, 7 wraps to 0.
  - HALT: phase held at 0, sync=0, no strobes.
- halt is sampled only in X3 (phase 7). If halt=1, the next state is HALT. Otherwise the next state is RUN with phase 0.
- In HALT: halt=0 leads to RUN at phase 0 on the next clock. halt is ignored in every phase other than X3.
- Nibble capture: opr<=bus_in at the M1 edge (phase 3); opa<=bus_in at the M2 edge (phase 4).
- Decode registers at X1 (phase 5); selects hold their values until the next X1.
- Write strobes are high only while phase=6 (X2), one cycle per instruction.
- illegal is updated at X1 and held for the whole cycle. An illegal opcode gives all strobes 0.
- Decode, as opr/opa -> op, in0, in1, cin, writes:
  - 0x6 INC: ADD, REG, ONE, ZERO; reg_we.
  - 0x8 ADD: ADD, REG, ACC, CARRY; acc_we, carry_we.
  - 0x9 SUB: ADD, REG_INV, ACC, CARRY_INV; acc_we, carry_we.
  - 0xA LD: PASS, REG, -, CARRY; acc_we.
  - 0xD LDM: PASS, DATA, -, CARRY; acc_we.
  - F0 CLB: PASS, DATA, -, ZERO; acc_we, carry_we (opa=0 gives result 0).
  - F1 CLC: PASS, ACC, -, ZERO; acc_we, carry_we.
  - F2 IAC: ADD, ACC, ONE, ZERO; acc_we, carry_we.
  - F3 CMC: PASS, ACC, -, CARRY_INV; acc_we, carry_we.
  - F4 CMA: PASS, ACC_INV, -, CARRY; acc_we.
  - F5 RAL: ROL, ACC, -, CARRY; acc_we, carry_we.
  - F6 RAR: ROR, ACC, -, CARRY; acc_we, carry_we.
  - F8 DAC: ADD, ACC, ONE_INV, ONE; acc_we, carry_we.
  - FA STC: PASS, ACC, -, ONE; acc_we, carry_we.
  - FB DAA: DEC_A, ACC, -, CARRY; acc_we, carry_we.
  - FC KBP: LG2_1, ACC, -, CARRY; acc_we.
  - Entries marked "-" drive in1=ACC.
- Every other opcode (F7, F9, FD-FF, and opr outside the set above) is illegal: selects take the reset defaults and illegal=1.
- Reset asserted in any phase: the next clock gives phase 0, RUN, and all strobes 0. A pending X2 write is cancelled.
- reset has priority over halt.

Test Plan:
- Reset and sequencing: after reset, free-run 16 clocks -> phase sequence 0..7,0..7; sync high only at phases 7 and 15; no strobes during the first cycle (opcode 0x00 is illegal).
- IAC: bus_in=0xF at M1, 0x2 at M2 -> at X2 alu_op=ADD, in0=ACC, in1=ONE, cin=ZERO, acc_we=1, carry_we=1, reg_we=0; strobes low in X3; illegal=0.
- SUB R5: bus_in 0x9 then 0x5 -> reg_addr=5, alu_data=5, in0=REG_INV, cin=CARRY_INV, acc_we and carry_we pulse once in X2. INC R3 (0x6, 0x3) -> reg_we only, with in1=ONE.
- Illegal: opcode F7 -> illegal=1 from X1 through the following A1..M2; zero strobes; next legal opcode F0 clears illegal at its X1.
- Halt: halt=1 at phase 2, dropped at phase 5 -> no effect. halt=1 held across X3 -> phase stays 0 and sync=0 for 5 clocks; drop halt -> RUN resumes at phase 0 with a fresh fetch.
- Reset mid-instruction: assert reset at phase 6 during ADD -> strobes 0 on the next clock, phase=0, opr=opa=0.
